// File: rtl/fp_round_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : fp_round_pkg
//  Purpose  : Shared types, flag indices and special-value encoder for the
//             parametrised floating-point round-and-pack stage.
//  Revision : 1.0 - initial parametrised release
// ============================================================================
package fp_round_pkg;

    typedef enum logic [1:0] {
        RNE = 2'd0,     // round to nearest, ties to even
        RTZ = 2'd1,     // round toward zero
        RDN = 2'd2,     // round toward -infinity
        RUP = 2'd3      // round toward +infinity
    } rnd_mode_e;

    localparam int FLAG_INEXACT   = 0;
    localparam int FLAG_UNDERFLOW = 2;
    localparam int FLAG_OVERFLOW  = 3;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        CLASS  = 3'd1,
        DENORM = 3'd2,
        ROUND  = 3'd3,
        DONE   = 3'd4
    } state_e;

    // Widest packed format the encoder can produce.
    localparam int ENC_MAX_W = 128;

    // Packed overflow result: infinity, or the largest finite magnitude.
    function automatic logic [ENC_MAX_W-1:0] special_enc(
        input int   exp_w,
        input int   frac_w,
        input logic sign,
        input logic inf
    );
        logic [ENC_MAX_W-1:0] one;
        logic [ENC_MAX_W-1:0] exp_all;
        logic [ENC_MAX_W-1:0] frac_all;
        logic [ENC_MAX_W-1:0] res;
        one      = {{(ENC_MAX_W-1){1'b0}}, 1'b1};
        exp_all  = (one << exp_w) - one;
        frac_all = (one << frac_w) - one;
        if (inf) begin
            res = exp_all << frac_w;
        end else begin
            res = ((exp_all - one) << frac_w) | frac_all;
        end
        res = res | ({{(ENC_MAX_W-1){1'b0}}, sign} << (exp_w + frac_w));
        return res;
    endfunction

endpackage
`default_nettype wire

// File: rtl/round_pack_float_param_shift_right_jam.sv
`default_nettype none
// ============================================================================
//  Module   : shift_right_jam
//  Purpose  : Combinational right shift that ORs every bit shifted out into
//             the result LSB. Shift counts >= W collapse to (i_val != 0).
//  Revision : 1.0 - initial release
// ============================================================================
module shift_right_jam #(
    parameter int W    = 64,
    parameter int SH_W = 13
) (
    input  logic [W-1:0]    i_val,
    input  logic [SH_W-1:0] i_shamt,
    output logic [W-1:0]    o_val
);

    logic [W-1:0] w_shifted;
    logic [W-1:0] w_lost_mask;
    logic         w_sticky;

    // Oversized shifts yield zero data and an all-ones mask, so the sticky
    // term alone carries the "any bit set" information.
    assign w_shifted   = i_val >> i_shamt;
    assign w_lost_mask = ~({W{1'b1}} << i_shamt);
    assign w_sticky    = |(i_val & w_lost_mask);
    assign o_val       = w_shifted | {{(W-1){1'b0}}, w_sticky};

endmodule
`default_nettype wire

// File: rtl/round_pack_float_param.sv
`default_nettype none
// ============================================================================
//  Module   : round_pack_float_param
//  Purpose  : Rounds a sign / biased exponent / left-aligned significand
//             triple into a packed IEEE-754 word of configurable width,
//             with four rounding modes, denormal handling and exception flags.
//  Revision : 1.0 - initial parametrised release
// ============================================================================
module round_pack_float_param
    import fp_round_pkg::*;
#(
    parameter int EXP_W  = 11,
    parameter int FRAC_W = 52,
    parameter int RB_W   = 10,
    parameter int FLAG_W = 32
) (
    input  logic                     ap_clk,
    input  logic                     ap_rst_n,
    input  logic                     ap_start,
    output logic                     ap_done,
    output logic                     ap_idle,
    output logic                     ap_ready,
    input  logic [1:0]               rnd_mode,
    input  logic                     zSign,
    input  logic [EXP_W+1:0]         zExp,
    input  logic [FRAC_W+RB_W+1:0]   zSig,
    input  logic [FLAG_W-1:0]        flags_i,
    output logic [FLAG_W-1:0]        flags_o,
    output logic                     flags_o_vld,
    output logic [EXP_W+FRAC_W:0]    ap_return
);

    localparam int SIG_W    = FRAC_W + RB_W + 2;
    localparam int c_ZE_W   = EXP_W + 2;
    localparam int c_RET_W  = 1 + EXP_W + FRAC_W;
    localparam int c_RSIG_W = SIG_W - RB_W;

    // Largest exponent that can still round to a finite value: the hidden
    // bit adds one to the field, and a rounding carry adds one more.
    localparam logic [c_ZE_W-1:0] c_OVF_EXP  = c_ZE_W'((2 ** EXP_W) - 3);
    localparam logic [SIG_W-1:0]  c_INC_HALF = SIG_W'(1) << (RB_W - 1);
    localparam logic [SIG_W-1:0]  c_INC_ALL  = (SIG_W'(1) << RB_W) - SIG_W'(1);
    localparam logic [RB_W-1:0]   c_RB_HALF  = RB_W'(1) << (RB_W - 1);
    localparam logic [FLAG_W-1:0] c_F_INX    = FLAG_W'(1) << FLAG_INEXACT;
    localparam logic [FLAG_W-1:0] c_F_UNF    = FLAG_W'(1) << FLAG_UNDERFLOW;
    localparam logic [FLAG_W-1:0] c_F_OVF    = FLAG_W'(1) << FLAG_OVERFLOW;

    state_e               r_state;
    state_e               w_next;
    logic                 r_sign;
    logic [c_ZE_W-1:0]    r_exp;
    logic [SIG_W-1:0]     r_sig;
    rnd_mode_e            r_mode;
    logic [FLAG_W-1:0]    r_flags_in;
    logic                 r_uflow;
    logic [c_RET_W-1:0]   r_ret;
    logic [FLAG_W-1:0]    r_flags_o;

    logic [SIG_W-1:0]     w_inc;
    logic [SIG_W-1:0]     w_sum;
    logic                 w_top;
    logic                 w_ovf;
    logic                 w_neg;
    logic [c_ZE_W-1:0]    w_shamt;
    logic [SIG_W-1:0]     w_jam;
    logic                 w_tiny;
    logic                 w_uf;
    logic [RB_W-1:0]      w_rb;
    logic [c_RSIG_W-1:0]  w_rsig;
    logic [EXP_W-1:0]     w_rexp;
    logic [c_RET_W-1:0]   w_packed;
    logic [c_RET_W-1:0]   w_ovf_ret;

    // Rounding increment added below the fraction LSB.
    always_comb begin
        w_inc = '0;
        case (r_mode)
            RNE:     w_inc = c_INC_HALF;
            RTZ:     w_inc = '0;
            RDN:     w_inc = r_sign ? c_INC_ALL : '0;
            RUP:     w_inc = r_sign ? '0 : c_INC_ALL;
            default: w_inc = '0;
        endcase
    end

    // A rounded significand reaching the top bit means the mantissa carried
    // past the hidden bit into the next binade.
    assign w_sum   = r_sig + w_inc;
    assign w_top   = w_sum[SIG_W-1];
    assign w_neg   = r_exp[c_ZE_W-1];
    assign w_ovf   = ($signed(r_exp) > $signed(c_OVF_EXP)) || ((r_exp == c_OVF_EXP) && w_top);
    assign w_shamt = -r_exp;

    shift_right_jam #(
        .W    (SIG_W),
        .SH_W (c_ZE_W)
    ) u_jam (
        .i_val   (r_sig),
        .i_shamt (w_shamt),
        .o_val   (w_jam)
    );

    // Tininess is judged before rounding unless the exponent is exactly -1,
    // where a rounding carry would lift the value back into the normal range.
    assign w_tiny = (w_neg && (r_exp != '1)) || !w_top;
    assign w_uf   = w_tiny && (w_jam[RB_W-1:0] != '0);

    // Final rounding and packing; the exponent is added rather than
    // concatenated so a hidden-bit carry bumps the exponent field.
    always_comb begin
        w_rb   = r_sig[RB_W-1:0];
        w_rsig = c_RSIG_W'(w_sum >> RB_W);
        if ((r_mode == RNE) && (w_rb == c_RB_HALF)) begin
            w_rsig[0] = 1'b0;
        end
        w_rexp   = (w_rsig == '0) ? '0 : r_exp[EXP_W-1:0];
        w_packed = (c_RET_W'(r_sign) << (EXP_W + FRAC_W))
                 + (c_RET_W'(w_rexp) << FRAC_W)
                 + c_RET_W'(w_rsig);
    end

    assign w_ovf_ret = c_RET_W'(special_enc(EXP_W, FRAC_W, r_sign, (w_inc != '0)));

    // State register.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state selection.
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = ap_start ? CLASS : IDLE;
            CLASS:   w_next = w_ovf ? DONE : (w_neg ? DENORM : ROUND);
            DENORM:  w_next = ROUND;
            ROUND:   w_next = DONE;
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Operand capture, denormalisation and result/flag registers.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            r_sign     <= 1'b0;
            r_exp      <= '0;
            r_sig      <= '0;
            r_mode     <= RNE;
            r_flags_in <= '0;
            r_uflow    <= 1'b0;
            r_ret      <= '0;
            r_flags_o  <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (ap_start) begin
                        r_sign     <= zSign;
                        r_exp      <= zExp;
                        r_sig      <= zSig;
                        r_mode     <= rnd_mode_e'(rnd_mode);
                        r_flags_in <= flags_i;
                        r_uflow    <= 1'b0;
                    end
                end
                CLASS: begin
                    if (w_ovf) begin
                        r_ret     <= w_ovf_ret;
                        r_flags_o <= r_flags_in | c_F_OVF | c_F_INX;
                    end
                end
                DENORM: begin
                    r_sig   <= w_jam;
                    r_exp   <= '0;
                    r_uflow <= w_uf;
                end
                ROUND: begin
                    r_ret     <= w_packed;
                    r_flags_o <= r_flags_in
                               | (r_uflow ? c_F_UNF : '0)
                               | ((w_rb != '0) ? c_F_INX : '0);
                end
                default: ;
            endcase
        end
    end

    assign ap_done     = (r_state == DONE);
    assign ap_ready    = ap_done;
    assign flags_o_vld = ap_done;
    assign ap_idle     = (r_state == IDLE) && !ap_start;
    assign ap_return   = r_ret;
    assign flags_o     = r_flags_o;

endmodule
`default_nettype wire

// File: tb/tb_round_pack_float_param.sv
`default_nettype none
// ============================================================================
//  Module   : tb_round_pack_float_param
//  Purpose  : Scoreboard bench for round_pack_float_param in double and
//             single precision configurations.
//  Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_round_pack_float_param;

    typedef struct {
        logic [63:0] ret;
        logic [31:0] flags;
        int          lat;
        int          start;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    int   cyc = 0;
    int   n_chk = 0;
    int   n_pass = 0;

    exp_t dq[$];
    exp_t fq[$];
    exp_t de;
    exp_t fe;

    // double-precision instance
    logic        d_start, d_sign, d_done, d_idle, d_ready, d_vld;
    logic [1:0]  d_mode;
    logic [12:0] d_exp;
    logic [63:0] d_sig, d_ret;
    logic [31:0] d_fi, d_fo;

    // single-precision instance
    logic        f_start, f_sign, f_done, f_idle, f_ready, f_vld;
    logic [1:0]  f_mode;
    logic [9:0]  f_exp;
    logic [31:0] f_sig, f_ret;
    logic [31:0] f_fi, f_fo;

    round_pack_float_param u_dut_d (
        .ap_clk(clk), .ap_rst_n(rst_n), .ap_start(d_start), .ap_done(d_done),
        .ap_idle(d_idle), .ap_ready(d_ready), .rnd_mode(d_mode), .zSign(d_sign),
        .zExp(d_exp), .zSig(d_sig), .flags_i(d_fi), .flags_o(d_fo),
        .flags_o_vld(d_vld), .ap_return(d_ret)
    );

    round_pack_float_param #(
        .EXP_W(8), .FRAC_W(23), .RB_W(7), .FLAG_W(32)
    ) u_dut_f (
        .ap_clk(clk), .ap_rst_n(rst_n), .ap_start(f_start), .ap_done(f_done),
        .ap_idle(f_idle), .ap_ready(f_ready), .rnd_mode(f_mode), .zSign(f_sign),
        .zExp(f_exp), .zSig(f_sig), .flags_i(f_fi), .flags_o(f_fo),
        .flags_o_vld(f_vld), .ap_return(f_ret)
    );

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_chk++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, req);
    endtask

    // double-precision monitor
    always @(negedge clk) begin
        if (rst_n && d_done) begin
            if (dq.size() == 0) begin
                check("dflt_unexpected_done", 64'(d_done), 64'd0);
            end else begin
                de = dq.pop_front();
                check("dflt_ret", d_ret, de.ret);
                check("dflt_flags", 64'(d_fo), 64'(de.flags));
                check("dflt_ready_vld", {62'd0, d_ready, d_vld}, 64'd3);
                if (de.lat > 0) check("dflt_latency", 64'(cyc - de.start + 1), 64'(de.lat));
            end
        end
    end

    // single-precision monitor
    always @(negedge clk) begin
        if (rst_n && f_done) begin
            if (fq.size() == 0) begin
                check("f32_unexpected_done", 64'(f_done), 64'd0);
            end else begin
                fe = fq.pop_front();
                check("f32_ret", 64'(f_ret), fe.ret);
                check("f32_flags", 64'(f_fo), 64'(fe.flags));
                check("f32_ready_vld", {62'd0, f_ready, f_vld}, 64'd3);
                if (fe.lat > 0) check("f32_latency", 64'(cyc - fe.start + 1), 64'(fe.lat));
            end
        end
    end

    task automatic wait_drain(input bit f32);
        for (int i = 0; i < 12; i++) begin
            if ((f32 ? fq.size() : dq.size()) == 0) break;
            @(negedge clk);
        end
        @(posedge clk);
        #1;
        if (f32) begin
            check("f32_drained", 64'(fq.size()), 64'd0);
            fq.delete();
        end else begin
            check("dflt_drained", 64'(dq.size()), 64'd0);
            dq.delete();
        end
    endtask

    task automatic run_op(input bit f32, input logic s, input logic [1:0] m,
                          input logic [12:0] e, input logic [63:0] sg,
                          input logic [31:0] fi, input logic [63:0] xret,
                          input logic [31:0] xfl, input int lat);
        exp_t x;
        @(negedge clk);
        if (f32) begin
            f_sign = s; f_mode = m; f_exp = e[9:0]; f_sig = sg[31:0]; f_fi = fi; f_start = 1'b1;
        end else begin
            d_sign = s; d_mode = m; d_exp = e; d_sig = sg; d_fi = fi; d_start = 1'b1;
        end
        @(posedge clk);
        #1;
        x.ret = xret; x.flags = xfl; x.lat = lat; x.start = cyc;
        if (f32) fq.push_back(x);
        else     dq.push_back(x);
        @(negedge clk);
        // inputs are don't-care once sampled
        if (f32) begin
            f_start = 1'b0; f_sig = '1; f_exp = '1; f_sign = ~s; f_mode = ~m; f_fi = '1;
        end else begin
            d_start = 1'b0; d_sig = '1; d_exp = '1; d_sign = ~s; d_mode = ~m; d_fi = '1;
        end
        wait_drain(f32);
    endtask

    initial begin
        exp_t x;
        int   n_done;
        rst_n = 1'b0;
        d_start = 0; d_sign = 0; d_mode = 0; d_exp = 0; d_sig = 0; d_fi = 0;
        f_start = 0; f_sign = 0; f_mode = 0; f_exp = 0; f_sig = 0; f_fi = 0;
        repeat (3) @(negedge clk);
        check("rst_ret", d_ret, 64'd0);
        check("rst_flags", 64'(d_fo), 64'd0);
        check("rst_done_ready_vld", {61'd0, d_done, d_ready, d_vld}, 64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_idle", {62'd0, d_idle, f_idle}, 64'd3);

        // normal values and rounding modes
        run_op(0, 0, 2'd0, 13'h3FE, 64'h4000_0000_0000_0000, 32'h10, 64'h3FF0_0000_0000_0000, 32'h10, 3);
        run_op(0, 0, 2'd0, 13'h3FE, 64'h4000_0000_0000_0200, 32'h0,  64'h3FF0_0000_0000_0000, 32'h1, 3);
        run_op(0, 0, 2'd3, 13'h3FE, 64'h4000_0000_0000_0200, 32'h0,  64'h3FF0_0000_0000_0001, 32'h1, 3);
        run_op(0, 0, 2'd1, 13'h3FE, 64'h4000_0000_0000_0200, 32'h0,  64'h3FF0_0000_0000_0000, 32'h1, 3);
        run_op(0, 1, 2'd2, 13'h3FE, 64'h4000_0000_0000_0200, 32'h0,  64'hBFF0_0000_0000_0001, 32'h1, 3);
        run_op(0, 0, 2'd0, 13'h3FE, 64'h7FFF_FFFF_FFFF_FFFF, 32'h0,  64'h4000_0000_0000_0000, 32'h1, 3);
        run_op(0, 0, 2'd0, 13'h3FE, 64'h0,                   32'h0,  64'h0,                   32'h0, 3);

        // overflow boundary
        run_op(0, 0, 2'd0, 13'h7FD, 64'h7FFF_FFFF_FFFF_FFFF, 32'h0,  64'h7FF0_0000_0000_0000, 32'h9, 0);
        run_op(0, 0, 2'd1, 13'h7FD, 64'h7FFF_FFFF_FFFF_FFFF, 32'h0,  64'h7FEF_FFFF_FFFF_FFFF, 32'h1, 0);
        run_op(0, 0, 2'd1, 13'h7FE, 64'h4000_0000_0000_0000, 32'h0,  64'h7FEF_FFFF_FFFF_FFFF, 32'h9, 0);
        repeat (3) @(negedge clk);
        check("hold_ret", d_ret, 64'h7FEF_FFFF_FFFF_FFFF);
        check("hold_flags", 64'(d_fo), 64'h9);
        run_op(0, 0, 2'd2, 13'h7FE, 64'h4000_0000_0000_0000, 32'h0,  64'h7FEF_FFFF_FFFF_FFFF, 32'h9, 0);
        run_op(0, 1, 2'd3, 13'h7FE, 64'h4000_0000_0000_0000, 32'h0,  64'hFFEF_FFFF_FFFF_FFFF, 32'h9, 0);
        run_op(0, 1, 2'd2, 13'h7FE, 64'h4000_0000_0000_0000, 32'h0,  64'hFFF0_0000_0000_0000, 32'h9, 0);

        // denormal and underflow
        run_op(0, 0, 2'd0, 13'h1FFF, 64'h4000_0000_0000_0000, 32'h0, 64'h0008_0000_0000_0000, 32'h0, 4);
        run_op(0, 0, 2'd0, 13'h1FFD, 64'h4000_0000_0000_0001, 32'h0, 64'h0002_0000_0000_0000, 32'h5, 4);

        // back-to-back with ap_start held high
        @(negedge clk);
        d_sign = 0; d_mode = 2'd3; d_exp = 13'h3FE; d_sig = 64'h4000_0000_0000_0200; d_fi = 0; d_start = 1'b1;
        @(posedge clk);
        #1;
        x.ret = 64'h3FF0_0000_0000_0001; x.flags = 32'h1; x.lat = 3; x.start = cyc;
        dq.push_back(x);
        repeat (4) @(posedge clk);
        #1;
        x.start = cyc;
        dq.push_back(x);
        @(negedge clk);
        d_start = 1'b0;
        wait_drain(0);

        // single-precision configuration
        run_op(1, 0, 2'd0, 13'h07E, 64'h4000_0000, 32'h0, 64'h3F80_0000, 32'h0, 3);

        // reset in the middle of an operation
        @(negedge clk);
        f_sign = 0; f_mode = 0; f_exp = 10'h07E; f_sig = 32'h4000_0001; f_fi = 0; f_start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        f_start = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        n_done = 0;
        repeat (2) begin
            @(negedge clk);
            if (f_done) n_done++;
        end
        rst_n = 1'b1;
        repeat (6) begin
            @(negedge clk);
            if (f_done) n_done++;
        end
        check("rst_mid_no_done", 64'(n_done), 64'd0);
        check("rst_mid_ret", 64'(f_ret), 64'd0);
        check("rst_mid_idle", 64'(f_idle), 64'd1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    // absolute time bound
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete, %0d checks made", n_chk);
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
